// File: rtl/jts16_obj_pkg.sv
// Shared definitions for the sprite object scanner: table word layout,
// scanner FSM encoding and the draw-command record.
package jts16_obj_pkg;

    // Word index of each field inside an 8-word object entry
    localparam logic [2:0] W_HDR   = 3'd0;
    localparam logic [2:0] W_XPOS  = 3'd1;
    localparam logic [2:0] W_PITCH = 3'd2;
    localparam logic [2:0] W_OFFS  = 3'd3;
    localparam logic [2:0] W_ATTR  = 3'd4;
    localparam logic [2:0] W_ZOOM  = 3'd5;
    localparam logic [2:0] W_SCR   = 3'd7;

    // A bottom value at or above this marks the end of the object list
    localparam logic [7:0] TERM_BOTTOM = 8'hF0;

    typedef enum logic [3:0] {
        ST_IDLE, ST_HDR, ST_XPOS, ST_PITCH, ST_OFFS,
        ST_ATTR, ST_ZOOM, ST_SCR, ST_WB, ST_PUSH
    } state_t;

    typedef struct packed {
        logic [8:0]  xpos;
        logic [15:0] offset;
        logic [3:0]  bank;
        logic [1:0]  prio;
        logic [5:0]  pal;
        logic [4:0]  zoom;
        logic        hflip;
    } cmd_t;

    // Table word each state consumes; its address goes out one cycle earlier
    function automatic logic [2:0] read_word(input state_t st);
        case (st)
            ST_XPOS:  return W_XPOS;
            ST_PITCH: return W_PITCH;
            ST_OFFS:  return W_OFFS;
            ST_ATTR:  return W_ATTR;
            ST_ZOOM:  return W_ZOOM;
            ST_SCR:   return W_SCR;
            default:  return W_HDR;
        endcase
    endfunction

endpackage

// File: rtl/jts16_obj_cmdq.sv
// Small synchronous FIFO holding draw commands between scanner and drawer.
module jts16_obj_cmdq #(
    parameter int W   = 8,
    parameter int QAW = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int DEPTH = 1 << QAW;

    logic [W-1:0] r_mem [DEPTH];
    logic [QAW:0] r_wr;
    logic [QAW:0] r_rd;

    assign empty = (r_wr == r_rd);
    assign full  = (r_wr[QAW] != r_rd[QAW]) && (r_wr[QAW-1:0] == r_rd[QAW-1:0]);
    assign dout  = r_mem[r_rd[QAW-1:0]];

    // Storage write
    // NOTE: the data array is deliberately not reset; the pointers alone say which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !full) r_mem[r_wr[QAW-1:0]] <= din;
    end

    // Pointer update; flush empties the queue in one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (push && !full) r_wr <= r_wr + 1'b1;
            if (pop && !empty) r_rd <= r_rd + 1'b1;
        end
    end

endmodule

// File: rtl/jts16_obj_scanq.sv
// Per-line sprite object scanner: walks the object table, advances the
// per-line source offset of every visible object and queues draw commands.
module jts16_obj_scanq
    import jts16_obj_pkg::*;
#(
    parameter int MODEL   = 0,
    parameter int OBJW    = 7,
    parameter int QAW     = 2,
    parameter int MAXLINE = 32,
    parameter int VLAST   = 223
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [OBJW+2:0] tbl_addr,
    input  logic [15:0]     tbl_dout,
    output logic [15:0]     tbl_din,
    output logic            tbl_we,
    output logic            dr_start,
    input  logic            dr_busy,
    output logic [8:0]      dr_xpos,
    output logic [15:0]     dr_offset,
    output logic [3:0]      dr_bank,
    output logic [1:0]      dr_prio,
    output logic [5:0]      dr_pal,
    output logic [4:0]      dr_zoom,
    output logic            dr_hflip,
    input  logic            flip,
    input  logic            hstart,
    input  logic [8:0]      vrender,
    output logic            done,
    output logic            line_ovf
);
    localparam int CW = $clog2(MAXLINE + 1);

    state_t          r_state, w_state_nxt;
    logic [OBJW-1:0] r_obj, w_obj_rd;
    logic [CW-1:0]   r_cnt;
    logic [8:0]      r_vrf;
    logic            r_first, r_wbz, r_done, r_ovf;
    logic [8:0]      r_xpos;
    logic [15:0]     r_pitch, r_cur;
    logic [3:0]      r_bank;
    logic [1:0]      r_prio;
    logic [5:0]      r_pal;
    logic [4:0]      r_vacc, r_vstep, r_hzoom;
    logic            r_hflip;

    logic            w_start, w_adv, w_end, w_ovf_set, w_push, w_pop, w_flush;
    logic            w_full, w_empty, w_carry;
    logic [8:0]      w_vrf;
    logic [7:0]      w_top, w_bot;
    logic [5:0]      w_zsum;
    logic [15:0]     w_new_off, w_zoom_wb;
    cmd_t            w_cmd, w_head;
    cmd_t            r_dr;
    logic            r_dr_start;

    assign w_vrf     = flip ? (9'(VLAST) - vrender) : vrender;
    assign w_bot     = tbl_dout[15:8];
    assign w_top     = tbl_dout[7:0];
    assign w_zsum    = {1'b0, r_vacc} + {1'b0, r_vstep};
    assign w_carry   = (MODEL == 1) && w_zsum[5];
    assign w_new_off = r_cur + (w_carry ? {r_pitch[14:0], 1'b0} : r_pitch);
    assign w_zoom_wb = {1'b0, w_zsum[4:0], r_vstep, r_hzoom};
    assign w_flush   = hstart && (r_state != ST_IDLE);
    assign w_pop     = !w_empty && !dr_busy && !r_dr_start && !w_flush;

    assign w_cmd = '{xpos: r_xpos, offset: r_cur, bank: r_bank, prio: r_prio, pal: r_pal,
                     zoom: (MODEL == 1) ? r_hzoom : 5'd0, hflip: r_hflip};

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; hstart overrides every state so a late line is aborted and restarted
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_adv       = 1'b0;
        w_end       = 1'b0;
        w_ovf_set   = 1'b0;
        if (hstart) begin
            if (w_vrf <= 9'(VLAST)) begin
                w_start     = 1'b1;
                w_state_nxt = ST_HDR;
            end else begin
                w_end       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        end else begin
            case (r_state)
                ST_HDR: begin
                    if (w_bot >= TERM_BOTTOM) begin
                        w_end = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (w_top >= w_bot || r_vrf[7:0] < w_top || r_vrf[7:0] >= w_bot) begin
                        if (&r_obj) begin
                            w_end = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_adv = 1'b1;
                        end
                    end else begin
                        w_state_nxt = ST_XPOS;
                    end
                end
                ST_XPOS:  w_state_nxt = ST_PITCH;
                ST_PITCH: w_state_nxt = ST_OFFS;
                ST_OFFS:  w_state_nxt = ST_ATTR;
                ST_ATTR:  w_state_nxt = (MODEL == 1) ? ST_ZOOM : (r_first ? ST_WB : ST_SCR);
                ST_ZOOM:  w_state_nxt = r_first ? ST_WB : ST_SCR;
                ST_SCR:   w_state_nxt = ST_WB;
                ST_WB:    w_state_nxt = (MODEL == 1 && !r_wbz) ? ST_WB : ST_PUSH;
                ST_PUSH: begin
                    if (!w_full) begin
                        if (r_cnt == CW'(MAXLINE - 1)) begin
                            w_end = 1'b1;
                            w_ovf_set = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else if (&r_obj) begin
                            w_end = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_adv = 1'b1;
                            w_state_nxt = ST_HDR;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs: read address for the next state's word, write-back strobes, FIFO push
    always_comb begin
        w_obj_rd = r_obj;
        if (w_start)    w_obj_rd = '0;
        else if (w_adv) w_obj_rd = r_obj + 1'b1;
        tbl_addr = {w_obj_rd, read_word(w_state_nxt)};
        tbl_we   = 1'b0;
        tbl_din  = '0;
        if (r_state == ST_WB && !hstart) begin
            tbl_we   = 1'b1;
            tbl_addr = {r_obj, r_wbz ? W_ZOOM : W_SCR};
            tbl_din  = r_wbz ? w_zoom_wb : w_new_off;
        end
        w_push = (r_state == ST_PUSH) && !hstart && !w_full;
    end

    // Line bookkeeping: object pointer, command count, done and overflow flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_obj  <= '0;
            r_cnt  <= '0;
            r_vrf  <= '0;
            r_wbz  <= 1'b0;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_start) begin
                r_obj <= '0;
                r_cnt <= '0;
                r_vrf <= w_vrf;
            end else begin
                if (w_adv)  r_obj <= r_obj + 1'b1;
                if (w_push) r_cnt <= r_cnt + 1'b1;
            end
            r_wbz <= (r_state == ST_WB) && (MODEL == 1) && !r_wbz && !hstart;
            if (w_end)       r_done <= 1'b1;
            else if (hstart) r_done <= 1'b0;
            if (w_ovf_set)   r_ovf <= 1'b1;
            else if (hstart) r_ovf <= 1'b0;
        end
    end

    // Entry field capture, one table word per state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first <= 1'b0;
            r_xpos  <= '0;
            r_pitch <= '0;
            r_cur   <= '0;
            r_bank  <= '0;
            r_prio  <= '0;
            r_pal   <= '0;
            r_vacc  <= '0;
            r_vstep <= '0;
            r_hzoom <= '0;
            r_hflip <= 1'b0;
        end else begin
            case (r_state)
                ST_HDR:  r_first <= (w_top == r_vrf[7:0]);
                ST_XPOS: r_xpos  <= tbl_dout[8:0];
                ST_PITCH: begin
                    if (MODEL == 1) begin
                        r_pitch <= {{8{tbl_dout[7]}}, tbl_dout[7:0]};
                        r_hflip <= tbl_dout[8];
                    end else begin
                        r_pitch <= tbl_dout;
                        r_hflip <= 1'b0;
                    end
                end
                ST_OFFS: if (r_first) r_cur <= tbl_dout;
                ST_ATTR: begin
                    if (MODEL == 1) begin
                        r_pal  <= tbl_dout[5:0];
                        r_prio <= tbl_dout[7:6];
                        r_bank <= tbl_dout[11:8];
                    end else begin
                        r_pal  <= tbl_dout[13:8];
                        r_prio <= tbl_dout[1:0];
                        r_bank <= {1'b0, tbl_dout[6:4]};
                    end
                end
                ST_ZOOM: begin
                    r_vacc  <= tbl_dout[14:10];
                    r_vstep <= tbl_dout[9:5];
                    r_hzoom <= tbl_dout[4:0];
                end
                ST_SCR:  r_cur <= tbl_dout;
                default: ;
            endcase
        end
    end

    jts16_obj_cmdq #(.W($bits(cmd_t)), .QAW(QAW)) u_cmdq (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (w_flush),
        .push  (w_push),
        .din   (w_cmd),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // Drain side: one command every other cycle at most, fields held until the next pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dr_start <= 1'b0;
            r_dr       <= '0;
        end else begin
            r_dr_start <= w_pop;
            if (w_pop) r_dr <= w_head;
        end
    end

    assign dr_start  = r_dr_start;
    assign dr_xpos   = r_dr.xpos;
    assign dr_offset = r_dr.offset;
    assign dr_bank   = r_dr.bank;
    assign dr_prio   = r_dr.prio;
    assign dr_pal    = r_dr.pal;
    assign dr_zoom   = r_dr.zoom;
    assign dr_hflip  = r_dr.hflip;
    assign done      = r_done;
    assign line_ovf  = r_ovf;

endmodule

// File: tb/tb_jts16_obj_scanq.sv
// Directed bench: an S16A scanner (u_a) and an S16B scanner limited to two
// commands per line (u_b), each with its own object table model.
module tb_jts16_obj_scanq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, hs_a, hs_b, flip, dr_busy, ld_a, ld_b;
    logic [8:0] vrender;
    int         cyc = 0;
    int         n_vec = 0, n_bad = 0;

    logic [5:0]  a_addr, b_addr;
    logic [15:0] a_dout, a_din, b_dout, b_din;
    logic        a_we, b_we;
    logic [15:0] ram_a [64], img_a [64], ram_b [64], img_b [64];

    logic        st_a, hf_a, dn_a, ovf_a, st_b, hf_b, dn_b, ovf_b;
    logic [8:0]  xp_a, xp_b;
    logic [15:0] of_a, of_b;
    logic [3:0]  bk_a, bk_b;
    logic [1:0]  pr_a, pr_b;
    logic [5:0]  pl_a, pl_b;
    logic [4:0]  zm_a, zm_b;

    logic [15:0] q_off_a [$], q_off_b [$];
    int          q_t_a [$];

    jts16_obj_scanq #(.MODEL(0), .OBJW(3), .QAW(2), .MAXLINE(32), .VLAST(223)) u_a (
        .clk(clk), .rst_n(rst_n), .tbl_addr(a_addr), .tbl_dout(a_dout), .tbl_din(a_din),
        .tbl_we(a_we), .dr_start(st_a), .dr_busy(dr_busy), .dr_xpos(xp_a), .dr_offset(of_a),
        .dr_bank(bk_a), .dr_prio(pr_a), .dr_pal(pl_a), .dr_zoom(zm_a), .dr_hflip(hf_a),
        .flip(flip), .hstart(hs_a), .vrender(vrender), .done(dn_a), .line_ovf(ovf_a));

    jts16_obj_scanq #(.MODEL(1), .OBJW(3), .QAW(2), .MAXLINE(2), .VLAST(223)) u_b (
        .clk(clk), .rst_n(rst_n), .tbl_addr(b_addr), .tbl_dout(b_dout), .tbl_din(b_din),
        .tbl_we(b_we), .dr_start(st_b), .dr_busy(dr_busy), .dr_xpos(xp_b), .dr_offset(of_b),
        .dr_bank(bk_b), .dr_prio(pr_b), .dr_pal(pl_b), .dr_zoom(zm_b), .dr_hflip(hf_b),
        .flip(flip), .hstart(hs_b), .vrender(vrender), .done(dn_b), .line_ovf(ovf_b));

    always @(posedge clk) cyc <= cyc + 1;

    // Object tables: registered read, write port, whole-image load from the stimulus
    always @(posedge clk) begin
        if (ld_a) ram_a <= img_a;
        else if (a_we) ram_a[a_addr] <= a_din;
        a_dout <= ram_a[a_addr];
        if (ld_b) ram_b <= img_b;
        else if (b_we) ram_b[b_addr] <= b_din;
        b_dout <= ram_b[b_addr];
    end

    // Draw-command log
    always @(negedge clk) begin
        if (st_a) begin
            q_off_a.push_back(of_a);
            q_t_a.push_back(cyc);
        end
        if (st_b) q_off_b.push_back(of_b);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_img(input bit sel);
        for (int i = 0; i < 64; i++) begin
            if (sel) img_b[i] = '0;
            else     img_a[i] = '0;
        end
    endtask

    task automatic ent(input bit sel, input int o, input logic [15:0] w0, w1, w2, w3, w4, w5, w7);
        logic [15:0] w [8];
        w = '{w0, w1, w2, w3, w4, w5, 16'h0, w7};
        for (int k = 0; k < 8; k++) begin
            if (sel) img_b[o*8+k] = w[k];
            else     img_a[o*8+k] = w[k];
        end
    endtask

    task automatic load(input bit sel);
        @(negedge clk);
        if (sel) ld_b = 1'b1; else ld_a = 1'b1;
        @(negedge clk);
        ld_a = 1'b0;
        ld_b = 1'b0;
        q_off_a.delete();
        q_t_a.delete();
        q_off_b.delete();
    endtask

    task automatic run_line(input bit sel, input logic [8:0] vr, input logic fl);
        @(negedge clk);
        vrender = vr;
        flip    = fl;
        if (sel) hs_b = 1'b1; else hs_a = 1'b1;
        @(negedge clk);
        hs_a = 1'b0;
        hs_b = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input string tag);
        int k = 0;
        while (((sel ? dn_b : dn_a) !== 1'b1) && k < 400) begin
            @(negedge clk);
            k++;
        end
        check(tag, sel ? dn_b : dn_a, 1);
        repeat (16) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; hs_a = 1'b0; hs_b = 1'b0; flip = 1'b0; dr_busy = 1'b0;
        ld_a = 1'b0; ld_b = 1'b0; vrender = '0;
        clr_img(0);
        clr_img(1);
        repeat (3) @(negedge clk);
        check("rst_start_a", st_a, 0);
        check("rst_done_a", dn_a, 0);
        check("rst_ovf_a", ovf_a, 0);
        check("rst_we_a", a_we, 0);
        check("rst_off_a", of_a, 0);
        check("rst_done_b", dn_b, 0);
        check("rst_start_b", st_b, 0);
        rst_n = 1'b1;

        // S16A single hit on its first line
        ent(0, 0, 16'h140A, 16'h0055, 16'h0040, 16'h1000, 16'h2A52, 16'h0, 16'h0);
        ent(0, 1, 16'hF000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        load(0);
        run_line(0, 9'd10, 1'b0);
        wait_done(0, "t1_done");
        check("t1_cnt", q_off_a.size(), 1);
        check("t1_off", q_off_a[0], 16'h1000);
        check("t1_xpos", xp_a, 9'h055);
        check("t1_bank", bk_a, 4'h5);
        check("t1_prio", pr_a, 2'd2);
        check("t1_pal", pl_a, 6'h2A);
        check("t1_zoom", zm_a, 0);
        check("t1_hflip", hf_a, 0);
        check("t1_w7", ram_a[7], 16'h1040);

        // Next line continues from the scratch offset; the bottom line is excluded
        q_off_a.delete();
        run_line(0, 9'd11, 1'b0);
        wait_done(0, "t2_done");
        check("t2_cnt", q_off_a.size(), 1);
        check("t2_off", q_off_a[0], 16'h1040);
        check("t2_w7", ram_a[7], 16'h1080);
        q_off_a.delete();
        run_line(0, 9'd20, 1'b0);
        wait_done(0, "t2b_done");
        check("t2b_cnt", q_off_a.size(), 0);
        check("t2b_w7", ram_a[7], 16'h1080);

        // Screen flip: vrender 213 maps to line 10
        load(0);
        run_line(0, 9'd213, 1'b1);
        wait_done(0, "t3_done");
        check("t3_cnt", q_off_a.size(), 1);
        check("t3_off", q_off_a[0], 16'h1000);
        check("t3_w7", ram_a[7], 16'h1040);

        // Line past VLAST: done at once, nothing scanned
        q_off_a.delete();
        run_line(0, 9'd230, 1'b0);
        wait_done(0, "t4_done");
        check("t4_cnt", q_off_a.size(), 0);

        // Entry with top >= bottom is skipped, the following one is drawn
        clr_img(0);
        ent(0, 0, 16'h0A14, 16'h0, 16'h0040, 16'h3000, 16'h0, 16'h0, 16'h0);
        ent(0, 1, 16'h140A, 16'h0, 16'h0040, 16'h2000, 16'h0, 16'h0, 16'h0);
        ent(0, 2, 16'hF000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        load(0);
        run_line(0, 9'd10, 1'b0);
        wait_done(0, "t5_done");
        check("t5_cnt", q_off_a.size(), 1);
        check("t5_off", q_off_a[0], 16'h2000);
        check("t5_w7_obj0", ram_a[7], 16'h0000);
        check("t5_w7_obj1", ram_a[15], 16'h2040);

        // S16B zoom carry with negative pitch
        ent(1, 0, 16'h140A, 16'h0123, 16'h01FE, 16'h5555, 16'h0AD5, 16'h7C2B, 16'h0100);
        ent(1, 1, 16'hF000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        load(1);
        run_line(1, 9'd12, 1'b0);
        wait_done(1, "t6_done");
        check("t6_cnt", q_off_b.size(), 1);
        check("t6_off", q_off_b[0], 16'h0100);
        check("t6_xpos", xp_b, 9'h123);
        check("t6_bank", bk_b, 4'hA);
        check("t6_prio", pr_b, 2'd3);
        check("t6_pal", pl_b, 6'h15);
        check("t6_zoom", zm_b, 5'h0B);
        check("t6_hflip", hf_b, 1);
        check("t6_w7", ram_b[7], 16'h00FC);
        check("t6_w5", ram_b[5], 16'h002B);

        // MAXLINE=2 with three hits
        clr_img(1);
        for (int i = 0; i < 3; i++)
            ent(1, i, 16'h140A, 16'h0, 16'h0010, 16'((i + 1) * 16'h0400), 16'h0, 16'h0, 16'h0);
        ent(1, 3, 16'hF000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        load(1);
        run_line(1, 9'd10, 1'b0);
        wait_done(1, "t7_done");
        check("t7_cnt", q_off_b.size(), 2);
        check("t7_off0", q_off_b[0], 16'h0400);
        check("t7_off1", q_off_b[1], 16'h0800);
        check("t7_ovf", ovf_b, 1);
        check("t7_w7_obj1", ram_b[15], 16'h0810);
        check("t7_w7_obj2", ram_b[23], 16'h0000);
        q_off_b.delete();
        run_line(1, 9'd30, 1'b0);
        wait_done(1, "t7b_done");
        check("t7b_ovf", ovf_b, 0);
        check("t7b_cnt", q_off_b.size(), 0);

        // Six hits against a busy drawer: queue fills, scanner stalls, then drains in order
        clr_img(0);
        for (int i = 0; i < 6; i++)
            ent(0, i, 16'h140A, 16'h0, 16'h0010, 16'(16'h1000 + i * 16'h0100), 16'h0, 16'h0, 16'h0);
        ent(0, 6, 16'hF000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        load(0);
        dr_busy = 1'b1;
        run_line(0, 9'd10, 1'b0);
        repeat (80) @(negedge clk);
        check("t8_stall_cnt", q_off_a.size(), 0);
        check("t8_stall_done", dn_a, 0);
        check("t8_w7_obj4", ram_a[39], 16'h1410);
        check("t8_w7_obj5", ram_a[47], 16'h0000);
        dr_busy = 1'b0;
        wait_done(0, "t8_done");
        check("t8_cnt", q_off_a.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("t8_off%0d", i), q_off_a[i], 16'h1000 + i * 16'h0100);
        for (int i = 1; i < 6; i++)
            check($sformatf("t8_gap%0d", i), (q_t_a[i] - q_t_a[i-1] >= 2), 1);

        // hstart mid-scan flushes the queue and restarts from object 0
        load(0);
        dr_busy = 1'b1;
        run_line(0, 9'd10, 1'b0);
        repeat (80) @(negedge clk);
        run_line(0, 9'd10, 1'b0);
        repeat (80) @(negedge clk);
        check("t9_stall_cnt", q_off_a.size(), 0);
        dr_busy = 1'b0;
        wait_done(0, "t9_done");
        check("t9_cnt", q_off_a.size(), 6);
        check("t9_off0", q_off_a[0], 16'h1000);
        check("t9_off5", q_off_a[5], 16'h1500);
        check("t9_w7_obj5", ram_a[47], 16'h1510);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
